cpu_run_checker: RTL and testbench
==================================

// Module: cpu_run_checker
// PURPOSE
//  On-chip run-and-compare engine for CPU regression on FPGA and in RTL sim.
//  Holds the CPU in reset, releases it for a bounded cycle budget, freezes dmem,
//  then walks NWORDS data words against an expected-value ROM and reports pass/fail.
//  Sits beside cpu/imem/dmem; drives the CPU reset, dmem write freeze and a shared read port.
// PARAMETERS
//  DATA_W      32    word width compared (dmem word = {mem3,mem2,mem1,mem0})
//  NWORDS      32    number of dmem words checked, indices 0..NWORDS-1
//  RUN_CYCLES  1000  CPU cycle budget (cycles with cpu_rst=0), >=1
//  HALT_CYCLES 16    consecutive cycles of unchanged iaddr counted as halted (macro only)
//  localparams: AW=$clog2(NWORDS), CW=$clog2(RUN_CYCLES+1), FW=$clog2(NWORDS+1)
// PORTS
//  clk            in   1       system clock, all state on posedge
//  reset          in   1       asynchronous, active-high
//  start          in   1       1-cycle request to begin a run; ignored unless IDLE or DONE
//  iaddr          in   32      CPU fetch address (monitor only)
//  cpu_rst        out  1       active-high reset to CPU
//  dmem_freeze    out  1       1 = dmem writes blocked (dwe forced 0 externally)
//  rd_en          out  1       read strobe, dmem and expected ROM
//  rd_addr        out  AW      word index, shared by dmem and expected ROM
//  dmem_rdata     in   DATA_W  dmem word, valid 1 cycle after rd_en
//  exp_rdata      in   DATA_W  expected word, valid 1 cycle after rd_en
//  busy           out  1       1 in RUN or CHECK
//  done           out  1       1 in DONE
//  pass           out  1       1 in DONE iff fail_count==0
//  fail_count     out  FW      mismatching words
//  first_fail     out  AW      index of first mismatch; 0 if none
//  run_len        out  CW      cycles actually spent in RUN
// BEHAVIOUR
//  Reset (async): state IDLE; cpu_rst=1, dmem_freeze=1, rd_en=0, rd_addr=0, busy=0,
//   done=0, pass=0, fail_count=0, first_fail=0, run_len=0. Reset mid-RUN/CHECK aborts immediately.
//  States: IDLE -> RUN -> CHECK -> DONE; DONE -start-> RUN.
//  IDLE: cpu_rst=1, dmem_freeze=1. start -> RUN next edge; clears fail_count, first_fail, run_len, done, pass.
//  RUN: cpu_rst=0, dmem_freeze=0, busy=1; run_len increments each RUN cycle.
//   Exit when run_len reaches RUN_CYCLES: cpu_rst=0 for exactly RUN_CYCLES cycles.
//  CHECK: cpu_rst=1, dmem_freeze=1. rd_en=1 for NWORDS consecutive cycles, rd_addr 0..NWORDS-1.
//   Compare registered one cycle later (pipelined, 1 word/cycle): dmem_rdata!=exp_rdata
//   -> fail_count+1; first mismatch latches first_fail. CHECK lasts NWORDS+1 cycles.
//  DONE: done=1, pass=(fail_count==0), results held; cpu_rst=1, dmem_freeze=1.
//  start during RUN/CHECK ignored. start and reset together: reset wins.
//  fail_count saturates never needed (FW holds NWORDS). NWORDS=1: single read, AW forced >=1.
// CONFIGURATION
//  CHK_HALT_DETECT_EN defined: in RUN, counter of consecutive cycles with iaddr equal to
//   previous cycle's iaddr; reaching HALT_CYCLES ends RUN early (next edge -> CHECK),
//   run_len reports cycles used. Counter clears on any iaddr change and on entering RUN.
//  Not defined: iaddr unused; RUN always lasts RUN_CYCLES.
// STRUCTURE
//  Package cpu_chk_pkg: state enum {IDLE,RUN,CHECK,DONE}, default widths DATA_W/NWORDS.
//  One sub-module natural: chk_halt_det (iaddr stability counter), instantiated
//   only under CHK_HALT_DETECT_EN. Rest is one FSM plus counters in this file.
// TESTING
//  T1 reset held 10 cycles -> cpu_rst=1, done=0, fail_count=0; start during reset ignored.
//  T2 RUN_CYCLES=1000, dmem==ROM all 32 words -> cpu_rst low exactly 1000 cycles, done, pass=1, run_len=1000.
//  T3 words 5 and 17 corrupted -> fail_count=2, first_fail=5, pass=0; rd_addr sweeps 0..31 once.
//  T4 reset asserted at RUN cycle 400 -> cpu_rst=1 same cycle (async), IDLE, outputs at reset values.
//  T5 start pulsed mid-CHECK ignored; start in DONE reruns with counters cleared.
//  T6 CHK_HALT_DETECT_EN, HALT_CYCLES=16, iaddr stuck from cycle 100 -> RUN ends, run_len=116; without macro run_len=1000.

Source files
------------

// File: rtl/cpu_chk_pkg.sv
// Shared types and default sizes for the CPU run-and-compare checker.
// Optional halt detection is enabled by defining CHK_HALT_DETECT_EN.
package cpu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NWORDS      = 32;
  localparam int DEF_RUN_CYCLES  = 1000;
  localparam int DEF_HALT_CYCLES = 16;

endpackage

// File: rtl/chk_halt_det.sv
// Counts consecutive RUN cycles whose fetch address equals the previous cycle's.
// Used by cpu_run_checker only when CHK_HALT_DETECT_EN is defined.
module chk_halt_det #(
  parameter int HALT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] iaddr,
  output logic        halt
);

  localparam int HW = $clog2(HALT_CYCLES + 1);

  logic [31:0]   prev_q;
  logic          have_prev_q;
  logic [HW-1:0] cnt_q;
  logic          same;

  // The first RUN cycle has no predecessor, so it can never count as "unchanged".
  assign same = have_prev_q && (iaddr == prev_q);
  assign halt = en && same && (cnt_q == HW'(HALT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else if (clr) begin
      have_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else if (en) begin
      prev_q      <= iaddr;
      have_prev_q <= 1'b1;
      if (!same)      cnt_q <= '0;
      else if (!halt) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_checker.sv
// Run-and-compare engine: releases the CPU for a cycle budget, then compares dmem to a ROM.
// Define CHK_HALT_DETECT_EN to end RUN early when iaddr stays unchanged for HALT_CYCLES.
module cpu_run_checker
  import cpu_chk_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NWORDS      = DEF_NWORDS,
  parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
  parameter int HALT_CYCLES = DEF_HALT_CYCLES,
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int CW = $clog2(RUN_CYCLES + 1),
  localparam int FW = $clog2(NWORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       iaddr,
  output logic              cpu_rst,
  output logic              dmem_freeze,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] exp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FW-1:0]     fail_count,
  output logic [AW-1:0]     first_fail,
  output logic [CW-1:0]     run_len,
  output chk_state_t        state_dbg
);

  // Handshake: start is a single-cycle request honoured only in IDLE or DONE;
  // rd_en/rd_addr is a strobe with no back-pressure, and dmem_rdata/exp_rdata
  // must hold the addressed words exactly one cycle after rd_en.

  localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);

  chk_state_t    state_q, state_d;
  logic [CW-1:0] run_len_q;
  logic [FW-1:0] fail_q;
  logic [AW-1:0] first_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          cmp_v_q;
  logic [AW-1:0] cmp_idx_q;
  logic          start_acc;
  logic          halt;
  logic          run_end;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef CHK_HALT_DETECT_EN
  chk_halt_det #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt_det (
    .clk   (clk),
    .rst   (reset),
    .clr   (start_acc),
    .en    (state_q == RUN),
    .iaddr (iaddr),
    .halt  (halt)
  );
`else
  logic unused_iaddr;
  assign unused_iaddr = ^iaddr;
  assign halt         = 1'b0;
`endif

  assign run_end = (run_len_q == CW'(RUN_CYCLES - 1)) || halt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (run_end) state_d = CHECK;
      CHECK:      if (cmp_v_q && (cmp_idx_q == LAST_IDX)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_len_q <= '0;
      fail_q    <= '0;
      first_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cmp_v_q   <= 1'b0;
      cmp_idx_q <= '0;
    end else begin
      cmp_v_q   <= rd_en_q;
      cmp_idx_q <= rd_addr_q;
      if (start_acc) begin
        run_len_q <= '0;
        fail_q    <= '0;
        first_q   <= '0;
        rd_addr_q <= '0;
      end
      if (state_q == RUN) begin
        run_len_q <= run_len_q + 1'b1;
        if (run_end) begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
      end
      // Read sweep issues one word per cycle; the last address is held afterwards.
      if (rd_en_q) begin
        if (rd_addr_q == LAST_IDX) rd_en_q   <= 1'b0;
        else                       rd_addr_q <= rd_addr_q + 1'b1;
      end
      if (cmp_v_q && (dmem_rdata != exp_rdata)) begin
        fail_q <= fail_q + 1'b1;
        if (fail_q == '0) first_q <= cmp_idx_q;
      end
    end
  end

  assign cpu_rst     = (state_q != RUN);
  assign dmem_freeze = (state_q != RUN);
  assign busy        = (state_q == RUN) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = (state_q == DONE) && (fail_q == '0);
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign fail_count  = fail_q;
  assign first_fail  = first_q;
  assign run_len     = run_len_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Self-checking bench for cpu_run_checker: table-driven corruption runs, random runs,
// reset abort and start-filtering sequences against a behavioural model.
module tb_cpu_run_checker;
  import cpu_chk_pkg::*;

  localparam int DATA_W      = 32;
  localparam int NWORDS      = 32;
  localparam int RUN_CYCLES  = 1000;
  localparam int HALT_CYCLES = 16;
  localparam int AW = 5;
  localparam int CW = 10;
  localparam int FW = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       iaddr = '0;
  logic              cpu_rst, dmem_freeze, rd_en, busy, done, pass;
  logic [AW-1:0]     rd_addr, first_fail;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic [DATA_W-1:0] exp_rdata = '0;
  logic [FW-1:0]     fail_count;
  logic [CW-1:0]     run_len;
  chk_state_t        state_dbg;

  logic [DATA_W-1:0] dmem [NWORDS];
  logic [DATA_W-1:0] rom  [NWORDS];

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_checker #(
    .DATA_W(DATA_W), .NWORDS(NWORDS), .RUN_CYCLES(RUN_CYCLES), .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .iaddr(iaddr),
    .cpu_rst(cpu_rst), .dmem_freeze(dmem_freeze), .rd_en(rd_en), .rd_addr(rd_addr),
    .dmem_rdata(dmem_rdata), .exp_rdata(exp_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail(first_fail), .run_len(run_len), .state_dbg(state_dbg)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      dmem_rdata <= dmem[rd_addr];
      exp_rdata  <= rom[rd_addr];
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_fail_count(input logic [NWORDS-1:0] mask);
    int n = 0;
    for (int i = 0; i < NWORDS; i++) if (mask[i]) n++;
    return n;
  endfunction

  function automatic int model_first_fail(input logic [NWORDS-1:0] mask);
    for (int i = 0; i < NWORDS; i++) if (mask[i]) return i;
    return 0;
  endfunction

  // Fetch address the "CPU" presents on RUN cycle k; from stuck_at it repeats cycle stuck_at-1.
  function automatic logic [31:0] iaddr_at(input int k, input int stuck_at);
    if (stuck_at > 0 && k >= stuck_at) return 32'((stuck_at - 1) * 4);
    return 32'(k * 4);
  endfunction

  function automatic int model_run_len(input int stuck_at);
`ifdef CHK_HALT_DETECT_EN
    int streak = 0;
    for (int k = 1; k < RUN_CYCLES; k++) begin
      streak = (iaddr_at(k, stuck_at) == iaddr_at(k - 1, stuck_at)) ? streak + 1 : 0;
      if (streak >= HALT_CYCLES) return k + 1;
    end
`endif
    return RUN_CYCLES;
  endfunction

  // ---------------- driver ----------------
  task automatic load_mem(input logic [NWORDS-1:0] mask);
    for (int i = 0; i < NWORDS; i++) begin
      rom[i]  = $urandom;
      dmem[i] = mask[i] ? (rom[i] ^ (32'h1 << $urandom_range(0, 31))) : rom[i];
    end
  endtask

  task automatic run_once(input logic [NWORDS-1:0] mask, input int stuck_at,
                          input bit pulse_in_check, input int exp_fail, input int exp_first);
    int k = 0;
    int rd_idx = 0;
    int guard = 0;
    bit sweep_ok = 1'b1;
    bit gap_ok = 1'b1;
    int exp_run;
    exp_run = model_run_len(stuck_at);
    load_mem(mask);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_clears_fail", fail_count, 0);
    chk("start_clears_busy", {busy, done}, 2'b10);
    while (!done && guard < 5000) begin
      start = 1'b0;
      if (!cpu_rst) begin
        if (k != guard) gap_ok = 1'b0;
        if (dmem_freeze !== 1'b0) gap_ok = 1'b0;
        iaddr = iaddr_at(k, stuck_at);
        k++;
      end
      if (rd_en) begin
        if (rd_addr !== AW'(rd_idx) || !cpu_rst || !dmem_freeze) sweep_ok = 1'b0;
        if (pulse_in_check && rd_idx == 10) start = 1'b1;
        rd_idx++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("done_timeout", guard < 5000, 1);
    chk("cpu_rst_low_cycles", k, exp_run);
    chk("cpu_rst_contiguous", gap_ok, 1);
    chk("run_len", run_len, exp_run);
    chk("rd_sweep_count", rd_idx, NWORDS);
    chk("rd_sweep_order", sweep_ok, 1);
    chk("check_len", guard - k, NWORDS + 1);
    chk("fail_count", fail_count, exp_fail);
    chk("first_fail", first_fail, exp_first);
    chk("pass", pass, exp_fail == 0);
    chk("done_outputs", {cpu_rst, dmem_freeze, busy, state_dbg}, {3'b110, DONE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NWORDS-1:0] mask;
    int exp_fail;
    int exp_first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 0};
    vecs[1] = '{32'h0002_0020, 2, 5};
    vecs[2] = '{32'h0000_0001, 1, 0};
    vecs[3] = '{32'h8000_0000, 1, 31};
    vecs[4] = '{32'hFFFF_FFFF, 32, 0};
    vecs[5] = '{32'h0000_0000, 0, 0};

    // T1: reset held with start asserted
    reset = 1'b1;
    start = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_freeze", dmem_freeze, 1);
    chk("rst_flags", {busy, done, pass, rd_en}, 4'b0000);
    chk("rst_counters", {fail_count, first_fail, run_len, rd_addr}, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, cpu_rst, state_dbg}, {2'b01, IDLE});

    // T2/T3/T5: table runs, start pulsed mid-CHECK on some, each rerun from DONE
    for (int v = 0; v < 6; v++)
      run_once(vecs[v].mask, -1, v[0], vecs[v].exp_fail, vecs[v].exp_first);

    // Random corruption patterns against the model
    for (int r = 0; r < 4; r++) begin
      logic [NWORDS-1:0] m;
      m = $urandom;
      if (r == 0) m = m & $urandom;
      run_once(m, -1, 1'($urandom_range(0, 1)), model_fail_count(m), model_first_fail(m));
    end

    // T4: asynchronous reset on RUN cycle 400
    begin
      int k = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (k < 400) begin
        if (!cpu_rst) k++;
        @(negedge clk);
      end
      chk("abort_in_run", cpu_rst, 0);
      #2 reset = 1'b1;
      #1;
      chk("abort_cpu_rst_async", cpu_rst, 1);
      chk("abort_outputs", {busy, done, pass, rd_en, dmem_freeze}, 5'b00001);
      chk("abort_counters", {fail_count, first_fail, run_len}, 0);
      chk("abort_state", state_dbg, IDLE);
      @(negedge clk) reset = 1'b0;
    end

    // T6: iaddr stuck from RUN cycle 100
    run_once('0, 100, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
